// File: rtl/sata_fis_data_extractor_if.sv
// ---------------------------------------------------------------------------
// sata_fis_data_extractor_if
// Bus bundle for the receive-side data FIS extractor.
//   i_*     : link-layer receive stream (one FIS per packet, CRC stripped)
//   o_*     : payload stream towards the transport/command layer
//   stat_*  : one status record per received frame
// Modports:
//   slave   : the extractor's view (consumes i_*, produces o_* and stat_*)
//   master  : the environment's view (drives i_*, o_rdy, stat_ready)
// ---------------------------------------------------------------------------
interface sata_fis_data_extractor_if;
    logic [31:0] i_dat;
    logic        i_val;
    logic        i_eop;
    logic        i_err;
    logic        i_rdy;

    logic [31:0] o_dat;
    logic        o_val;
    logic        o_eop;
    logic        o_rdy;

    logic        stat_valid;
    logic [11:0] stat_count;
    logic        stat_err_type;
    logic        stat_err_len;
    logic        stat_err_crc;
    logic        stat_ready;

    modport slave (
        input  i_dat, i_val, i_eop, i_err, o_rdy, stat_ready,
        output i_rdy, o_dat, o_val, o_eop,
               stat_valid, stat_count, stat_err_type, stat_err_len, stat_err_crc
    );

    modport master (
        output i_dat, i_val, i_eop, i_err, o_rdy, stat_ready,
        input  i_rdy, o_dat, o_val, o_eop,
               stat_valid, stat_count, stat_err_type, stat_err_len, stat_err_crc
    );
endinterface

// File: rtl/sata_fis_data_extractor.sv
// ---------------------------------------------------------------------------
// sata_fis_data_extractor
// Checks that word 0 of each received frame is a DATA FIS header (type 0x46),
// strips it, and forwards the payload dwords as a packet stream. Every input
// frame produces exactly one status record (payload count + error flags).
// Ports:
//   clk   : clock
//   reset : asynchronous reset, active-high
//   bus   : sata_fis_data_extractor_if.slave (input stream, output stream,
//           status record)
// Parameters:
//   MAX_WORDS : maximum payload dwords forwarded per frame (1..2048)
// ---------------------------------------------------------------------------
module sata_fis_data_extractor #(
    parameter int MAX_WORDS = 2048
) (
    input  logic                        clk,
    input  logic                        reset,
    sata_fis_data_extractor_if.slave    bus
);

    localparam logic [7:0]  DATA_FIS_TYPE = 8'h46;
    localparam logic [11:0] LAST_IDX      = 12'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2,
        STAT = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [11:0] count_reg, count_next;
    logic        err_type_reg, err_type_next;
    logic        err_len_reg,  err_len_next;
    logic        err_crc_reg,  err_crc_next;

    logic        at_max;
    logic        in_xfer;

    // Index of the payload word currently presented is the last one allowed.
    assign at_max  = (count_reg == LAST_IDX);
    assign in_xfer = bus.i_val & bus.i_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= HEAD;
            count_reg    <= '0;
            err_type_reg <= 1'b0;
            err_len_reg  <= 1'b0;
            err_crc_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            err_type_reg <= err_type_next;
            err_len_reg  <= err_len_next;
            err_crc_reg  <= err_crc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        err_type_next = err_type_reg;
        err_len_next  = err_len_reg;
        err_crc_next  = err_crc_reg;
        bus.i_rdy     = 1'b0;
        bus.o_val     = 1'b0;
        bus.o_eop     = 1'b0;
        bus.o_dat     = bus.i_dat;
        bus.stat_valid = 1'b0;

        unique case (state_reg)
            HEAD: begin
                bus.i_rdy = 1'b1;
                if (in_xfer) begin
                    if (bus.i_dat[7:0] == DATA_FIS_TYPE) begin
                        count_next = '0;
                        if (bus.i_eop) begin
                            // Header-only DATA FIS: nothing to forward.
                            err_len_next = 1'b1;
                            err_crc_next = bus.i_err;
                            state_next   = STAT;
                        end else begin
                            state_next   = PASS;
                        end
                    end else begin
                        err_type_next = 1'b1;
                        if (bus.i_eop) begin
                            err_crc_next = bus.i_err;
                            state_next   = STAT;
                        end else begin
                            state_next   = DROP;
                        end
                    end
                end
            end

            PASS: begin
                // Zero-latency pass-through; downstream ready gates upstream.
                bus.o_val = bus.i_val;
                bus.i_rdy = bus.o_rdy;
                bus.o_eop = bus.i_eop | at_max;
                if (in_xfer) begin
                    count_next = count_reg + 12'd1;
                    if (bus.i_eop) begin
                        // i_err only matters on the closing word here.
                        err_crc_next = bus.i_err;
                        state_next   = STAT;
                    end else if (at_max) begin
                        // Output packet already closed by the forced o_eop;
                        // discard the remainder of the oversize frame.
                        err_len_next = 1'b1;
                        state_next   = DROP;
                    end
                end
            end

            DROP: begin
                bus.i_rdy = 1'b1;
                if (in_xfer) begin
                    err_crc_next = err_crc_reg | bus.i_err;
                    if (bus.i_eop) begin
                        state_next = STAT;
                    end
                end
            end

            STAT: begin
                bus.stat_valid = 1'b1;
                if (bus.stat_ready) begin
                    count_next    = '0;
                    err_type_next = 1'b0;
                    err_len_next  = 1'b0;
                    err_crc_next  = 1'b0;
                    state_next    = HEAD;
                end
            end

            default: begin
                state_next = HEAD;
            end
        endcase
    end

    assign bus.stat_count    = count_reg;
    assign bus.stat_err_type = err_type_reg;
    assign bus.stat_err_len  = err_len_reg;
    assign bus.stat_err_crc  = err_crc_reg;

endmodule

// File: tb/tb_sata_fis_data_extractor.sv
// ---------------------------------------------------------------------------
// tb_sata_fis_data_extractor
// Table of frames applied in a loop with expected payload words and status
// records queued on a scoreboard; hand-written sequences for backpressure,
// delayed status acceptance and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_sata_fis_data_extractor;

    localparam int MAXW = 8;

    typedef struct {
        logic [7:0] hdr;
        int         npay;
        logic       err;
        int         exp_count;
        logic       exp_type;
        logic       exp_len;
        logic       exp_crc;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        eop;
    } out_t;

    typedef struct {
        logic [11:0] cnt;
        logic        t;
        logic        l;
        logic        c;
    } st_t;

    logic clk;
    logic reset;

    sata_fis_data_extractor_if bus ();

    sata_fis_data_extractor #(.MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   cmp_count = 0;
    int   err_count = 0;
    out_t out_q[$];
    st_t  st_q[$];
    vec_t vecs[10];

    bit   toggle_ordy = 0;
    int   stat_delay  = 0;
    int   stat_wait   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        cmp_count++;
        if (act !== req) begin
            err_count++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Downstream ready pattern and status acceptance, updated on negedges.
    initial begin
        bus.o_rdy = 1'b1;
        bus.stat_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.o_rdy = toggle_ordy ? ~bus.o_rdy : 1'b1;
            if (bus.stat_valid) begin
                if (stat_wait >= stat_delay) bus.stat_ready = 1'b1;
                else begin
                    bus.stat_ready = 1'b0;
                    stat_wait++;
                end
            end else begin
                bus.stat_ready = 1'b0;
                stat_wait = 0;
            end
        end
    end

    // Monitor: samples settled signals mid-low-phase; transfers complete
    // on the following rising edge.
    initial begin
        out_t o_exp;
        st_t  s_exp;
        st_t  held;
        bit   prev_sv = 0;
        bit   prev_sr = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_sv = 0;
                continue;
            end
            if (bus.o_val && bus.o_rdy) begin
                $display("out  dat=%h eop=%b", bus.o_dat, bus.o_eop);
                if (out_q.size() == 0) begin
                    check("unexpected_out", {32'd0, bus.o_dat}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    o_exp = out_q.pop_front();
                    check("out_dat", {32'd0, bus.o_dat}, {32'd0, o_exp.dat});
                    check("out_eop", {63'd0, bus.o_eop}, {63'd0, o_exp.eop});
                end
            end
            if (bus.o_val && !bus.o_rdy)
                check("i_rdy_stall", {63'd0, bus.i_rdy}, 64'd0);
            if (bus.stat_valid) begin
                check("i_rdy_in_stat", {63'd0, bus.i_rdy}, 64'd0);
                check("o_val_in_stat", {63'd0, bus.o_val}, 64'd0);
                if (prev_sv && !prev_sr)
                    check("stat_hold", {48'd0, bus.stat_count, bus.stat_err_type, bus.stat_err_len, bus.stat_err_crc},
                          {48'd0, held.cnt, held.t, held.l, held.c});
                held = '{bus.stat_count, bus.stat_err_type, bus.stat_err_len, bus.stat_err_crc};
            end
            if (bus.stat_valid && bus.stat_ready) begin
                $display("stat count=%0d type=%b len=%b crc=%b", bus.stat_count,
                         bus.stat_err_type, bus.stat_err_len, bus.stat_err_crc);
                if (st_q.size() == 0) begin
                    check("unexpected_stat", {52'd0, bus.stat_count}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    s_exp = st_q.pop_front();
                    check("stat_count", {52'd0, bus.stat_count}, {52'd0, s_exp.cnt});
                    check("stat_flags", {61'd0, bus.stat_err_type, bus.stat_err_len, bus.stat_err_crc},
                          {61'd0, s_exp.t, s_exp.l, s_exp.c});
                end
            end
            prev_sv = bus.stat_valid;
            prev_sr = bus.stat_ready;
        end
    end

    // Drive one word and hold it until accepted. Entered and left on a negedge.
    task automatic drive_word(input logic [31:0] d, input logic eop, input logic err);
        int  n = 0;
        bit  hs = 0;
        bus.i_dat = d;
        bus.i_val = 1'b1;
        bus.i_eop = eop;
        bus.i_err = err;
        while (!hs) begin
            #1;
            hs = bus.i_rdy;
            @(negedge clk);
            n++;
            if (!hs && n > 500) begin
                check("input_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.i_val = 1'b0;
        bus.i_eop = 1'b0;
        bus.i_err = 1'b0;
    endtask

    function automatic logic [31:0] hdr_word(input int idx, input logic [7:0] hdr);
        return {16'hC0DE, 8'(idx), hdr};
    endfunction

    function automatic logic [31:0] pay_word(input int idx, input int i);
        return 32'hA000_0000 | (32'(idx) << 8) | 32'(i);
    endfunction

    // Send header plus the first nsend-1 payload words; eop only on the true last word.
    task automatic send_frame(input int idx, input logic [7:0] hdr, input int npay,
                              input logic err, input int nsend);
        for (int i = 0; i < nsend; i++) begin
            logic last;
            last = (i == npay);
            drive_word(i == 0 ? hdr_word(idx, hdr) : pay_word(idx, i), last, last & err);
        end
    endtask

    task automatic expect_payload(input int idx, input int nout);
        for (int i = 1; i <= nout; i++)
            out_q.push_back('{pay_word(idx, i), (i == nout)});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((st_q.size() != 0 || out_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", {32'(st_q.size()), 32'(out_q.size())}, 64'd0);
    endtask

    initial begin
        int nout;
        vecs[0] = '{8'h46, 4,  1'b0, 4, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h34, 2,  1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h46, 1,  1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h46, 0,  1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h46, 2,  1'b1, 2, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h46, 10, 1'b0, 8, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h46, 8,  1'b0, 8, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h34, 0,  1'b1, 0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{8'h46, 9,  1'b1, 8, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{8'h00, 3,  1'b1, 0, 1'b1, 1'b0, 1'b1};

        bus.i_dat = '0;
        bus.i_val = 1'b0;
        bus.i_eop = 1'b0;
        bus.i_err = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_i_rdy",      {63'd0, bus.i_rdy}, 64'd1);
        check("rst_o_val",      {63'd0, bus.o_val}, 64'd0);
        check("rst_o_eop",      {63'd0, bus.o_eop}, 64'd0);
        check("rst_stat_valid", {63'd0, bus.stat_valid}, 64'd0);
        check("rst_stat",       {49'd0, bus.stat_count, bus.stat_err_type, bus.stat_err_len, bus.stat_err_crc}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven frames, o_rdy and stat_ready always high.
        for (int v = 0; v < 10; v++) begin
            nout = (vecs[v].hdr != 8'h46) ? 0 : (vecs[v].npay > MAXW ? MAXW : vecs[v].npay);
            expect_payload(v, nout);
            st_q.push_back('{12'(vecs[v].exp_count), vecs[v].exp_type, vecs[v].exp_len, vecs[v].exp_crc});
            send_frame(v, vecs[v].hdr, vecs[v].npay, vecs[v].err, vecs[v].npay + 1);
        end
        wait_idle();

        // Backpressure: o_rdy toggling, status accepted 5 cycles late.
        toggle_ordy = 1;
        stat_delay  = 5;
        expect_payload(16, 4);
        st_q.push_back('{12'd4, 1'b0, 1'b0, 1'b0});
        send_frame(16, 8'h46, 4, 1'b0, 5);
        expect_payload(17, 3);
        st_q.push_back('{12'd3, 1'b0, 1'b0, 1'b0});
        send_frame(17, 8'h46, 3, 1'b0, 4);
        wait_idle();
        toggle_ordy = 0;
        stat_delay  = 0;

        // Reset after 3 payload words of a 6-word frame.
        expect_payload(18, 3);
        out_q[2].eop = 1'b0;   // partial packet: no eop ever emitted
        send_frame(18, 8'h46, 6, 1'b0, 4);
        reset = 1'b1;
        #2;
        check("midrst_o_val",      {63'd0, bus.o_val}, 64'd0);
        check("midrst_o_eop",      {63'd0, bus.o_eop}, 64'd0);
        check("midrst_stat_valid", {63'd0, bus.stat_valid}, 64'd0);
        check("midrst_i_rdy",      {63'd0, bus.i_rdy}, 64'd1);
        check("midrst_pending_out", {32'd0, 32'(out_q.size())}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_stat", {63'd0, bus.stat_valid}, 64'd0);
        expect_payload(19, 6);
        st_q.push_back('{12'd6, 1'b0, 1'b0, 1'b0});
        send_frame(19, 8'h46, 6, 1'b0, 7);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
